// File: rtl/uart_rx_fifo.sv
// UART receiver with a runtime bit-period divisor, optional parity, 1/2 stop bits,
// and a show-ahead receive FIFO with overrun tracking and RTS flow control.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DIV_W        = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [1:0]              cfg_parity,
  input  logic                    cfg_stop2,
  output logic                    uart_rts,
  input  logic                    rx_read,
  output logic                    rx_valid,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_parity_err,
  output logic                    rx_frame_err,
  output logic                    rx_overrun,
  input  logic                    err_clr,
  output logic [LW-1:0]           rx_level
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  localparam int EW = PAYLOAD_BITS + 2;

  state_t state_q, state_d;
  logic [1:0]              sync_q;
  logic [DIV_W-1:0]        div_q, cnt_q;
  logic [1:0]              par_q;
  logic                    stop2_q, perr_q, ferr_q;
  logic [2:0]              bit_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    rxs, mid, last, par_en, last_data, last_stop;
  logic                    start_go, data_smp, par_smp, stop_smp, push;

  assign rxs       = sync_q[1];
  assign mid       = (cnt_q == (div_q >> 1));
  assign last      = (cnt_q == div_q - DIV_W'(1));
  assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
  assign last_data = (bit_q == 3'(PAYLOAD_BITS - 1));
  assign last_stop = (bit_q[0] == stop2_q);

  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rxd};

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rxs) state_d = S_START;
      S_START:  if (mid && rxs) state_d = S_IDLE;
                else if (last) state_d = S_DATA;
      S_DATA:   if (last && last_data) state_d = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (last) state_d = S_STOP;
      S_STOP:   if (mid && last_stop) state_d = rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_go = (state_q == S_IDLE) && !rxs;
    data_smp = (state_q == S_DATA) && mid;
    par_smp  = (state_q == S_PARITY) && mid;
    stop_smp = (state_q == S_STOP) && mid;
    push     = stop_smp && last_stop;
  end

  // Config is captured once per frame so mid-frame changes cannot corrupt it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div_q <= '0; par_q <= '0; stop2_q <= 1'b0;
      cnt_q <= '0; bit_q <= '0; shift_q <= '0; perr_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE || state_q == S_BREAK || last) cnt_q <= '0;
      else                                                 cnt_q <= cnt_q + DIV_W'(1);
      if (start_go) begin
        div_q <= cfg_div; par_q <= cfg_parity; stop2_q <= cfg_stop2;
        bit_q <= '0; perr_q <= 1'b0; ferr_q <= 1'b0;
      end
      if (data_smp) shift_q <= {rxs, shift_q[PAYLOAD_BITS-1:1]};
      if (state_q == S_DATA && last) bit_q <= last_data ? 3'd0 : bit_q + 3'd1;
      if (state_q == S_STOP && last) bit_q <= bit_q + 3'd1;
      if (par_smp)  perr_q <= (^shift_q) ^ rxs ^ (par_q == 2'b10);
      if (stop_smp && !rxs) ferr_q <= 1'b1;
    end

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ovr_q, rts_q, do_pop, do_push, drop;
  logic [EW-1:0]   head;

  // A full FIFO still accepts a frame when the head is popped on the same edge.
  assign do_pop  = rx_read && (level_q != '0);
  assign do_push = push && ((level_q != LW'(FIFO_DEPTH)) || do_pop);
  assign drop    = push && !do_push;
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge clk)
    if (do_push) mem[wptr_q] <= {ferr_q | ~rxs, perr_q, shift_q};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr_q <= '0; rptr_q <= '0; level_q <= '0; ovr_q <= 1'b0; rts_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      if (drop)         ovr_q <= 1'b1;
      else if (err_clr) ovr_q <= 1'b0;
      rts_q <= (level_d >= LW'(FIFO_DEPTH - 1));
    end

  assign head          = rx_valid ? mem[rptr_q] : '0;
  assign rx_valid      = (level_q != '0);
  assign rx_data       = head[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head[PAYLOAD_BITS];
  assign rx_frame_err  = head[PAYLOAD_BITS+1];
  assign rx_overrun    = ovr_q;
  assign rx_level      = level_q;
  assign uart_rts      = rts_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: p10_uart_rx_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame (legal range 5..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of the runtime bit-period divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port uart_rxd, input, 1, serial line, idle high.
REQ-007 SHALL have port cfg_div, input, DIV_W, clk cycles per bit (legal range at least 4).
REQ-008 SHALL have port cfg_parity, input, 2, parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 SHALL have port cfg_stop2, input, 1, 1 = two stop bits expected.
REQ-010 SHALL have port uart_rts, output, 1, active-low request-to-send.
REQ-011 SHALL have port rx_read, input, 1, pop FIFO head.
REQ-012 SHALL have port rx_valid, output, 1, FIFO not empty.
REQ-013 SHALL have port rx_data, output, PAYLOAD_BITS, FIFO head data (show-ahead).
REQ-014 SHALL have port rx_parity_err, output, 1, parity error flag of FIFO head.
REQ-015 SHALL have port rx_frame_err, output, 1, framing error flag of FIFO head.
REQ-016 SHALL have port rx_overrun, output, 1, sticky flag: a frame was dropped.
REQ-017 SHALL have port err_clr, input, 1, clears rx_overrun.
REQ-018 SHALL have port rx_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.

Function
REQ-019 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 11); all sampling uses the synchronized value.
REQ-020 SHALL latch cfg_div, cfg_parity and cfg_stop2 on leaving IDLE; config changes mid-frame SHALL NOT affect the current frame.
REQ-021 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-022 In IDLE, a synchronized low SHALL move to START with the bit counter cleared.
REQ-023 SHALL sample the line when the bit counter equals div>>1 (mid-bit) and SHALL advance to the next bit when the counter equals div-1, then reset the counter to 0.
REQ-024 START: a high mid-bit sample SHALL be a false start, returning to IDLE with no push and no flags.
REQ-025 DATA: SHALL shift in PAYLOAD_BITS bits LSB first, then go to PARITY if parity is enabled, else to STOP.
REQ-026 PARITY: parity_err SHALL be set if XOR(data, parity bit) is not 0 (even) or not 1 (odd).
REQ-027 STOP: SHALL sample 1 or 2 stop bits; frame_err SHALL be set if any stop sample is low.
REQ-028 At the mid-bit of the last stop bit, SHALL push {frame_err, parity_err, data}; SHALL then go to IDLE if the sample is high, or to BREAK if it is low.
REQ-029 BREAK: SHALL wait for a synchronized high, then go to IDLE.
REQ-030 rx_valid, rx_data and the error flags SHALL reflect the new entry in the cycle after the push edge when the FIFO was empty.
REQ-031 rx_read with rx_valid SHALL pop the head on that edge; rx_read while empty SHALL be ignored.
REQ-032 A push while full without a simultaneous pop SHALL drop the frame and set rx_overrun; a push and pop on the same edge while full SHALL both succeed, with no overrun.
REQ-033 err_clr SHALL clear rx_overrun; if a drop and err_clr occur on the same edge, rx_overrun SHALL be set.
REQ-034 uart_rts SHALL be a register equal to (rx_level >= FIFO_DEPTH-1), i.e. deasserted high when at most one free entry remains.
REQ-035 The pointers SHALL wrap modulo FIFO_DEPTH; rx_level SHALL range from 0 to FIFO_DEPTH.

Reset
REQ-036 Reset SHALL take effect asynchronously at any time, including mid-frame, and SHALL abandon the frame without a push.
REQ-037 During reset: state IDLE, counter 0, FIFO empty, rx_valid 0, rx_data 0, rx_parity_err 0, rx_frame_err 0, rx_overrun 0, rx_level 0, uart_rts 1.
REQ-038 uart_rts SHALL go low on the first clock after reset release.

Verification
REQ-039 cfg_div=8, no parity, 1 stop, send 0xA5 -> one entry: rx_data=A5, both error flags 0, rx_level=1.
REQ-040 Even parity, send 0x03 with parity bit 1 -> rx_data=03, rx_parity_err=1; odd parity, same frame -> rx_parity_err=0.
REQ-041 A 2-cycle low glitch with cfg_div=16 -> no push, state returns to IDLE.
REQ-042 cfg_stop2=1, second stop bit low -> rx_frame_err=1; line held low for 40 cycles -> stays in BREAK, no extra push.
REQ-043 FIFO_DEPTH=4, send 5 frames with no reads -> rx_level=4, rx_overrun=1, head = first byte, uart_rts=1 from level 3; err_clr -> rx_overrun=0.
REQ-044 Assert reset at mid-DATA, release, then send 0x3C -> only 0x3C is received.
